// File: rtl/nb_pkg.sv
// rtl/nb_pkg.sv - shared constants, arbitration priority type and bank slice helper for nb_banked_mem
package nb_pkg;
  localparam int NB_N          = 16;
  localparam int NB_TN         = 16;
  localparam int NB_DEPTH      = 64;
  localparam int NB_BANKS      = 2;
  localparam int NB_FIFO_DEPTH = 2;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  function automatic int slice_w(input int ww, input int banks);
    return ww / banks;
  endfunction
endpackage

// File: rtl/nb_bank.sv
// rtl/nb_bank.sv - behavioural synchronous single-port RAM, active-low CEN/WEN, 1-cycle read
module nb_bank #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          cen_i,
  input  logic          wen_i,
  input  logic [AW-1:0] a_i,
  input  logic [W-1:0]  d_i,
  output logic [W-1:0]  q_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!cen_i) begin
      if (!wen_i) mem_q[a_i] <= d_i;
      else        q_o        <= mem_q[a_i];
    end
  end
endmodule

// File: rtl/nb_banked_mem.sv
// rtl/nb_banked_mem.sv - banked word memory with alternating read/write arbitration and 2-entry read FIFO
// Optional per-bank even parity enabled by defining NB_PARITY_EN.
module nb_banked_mem
  import nb_pkg::*;
#(
  parameter int N     = NB_N,
  parameter int Tn    = NB_TN,
  parameter int DEPTH = NB_DEPTH,
  parameter int BANKS = NB_BANKS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [N*Tn-1:0]          i_wr_data,
  input  logic                     i_rd_valid,
  output logic                     o_rd_ready,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [N*Tn-1:0]          o_rd_data,
  output logic                     o_par_err
);
  localparam int WW   = N * Tn;
  localparam int ADDR = $clog2(DEPTH);
  localparam int SW   = slice_w(WW, BANKS);
`ifdef NB_PARITY_EN
  localparam int BW   = SW + 1;
`else
  localparam int BW   = SW;
`endif
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [1:0]  cnt_q, cnt_d, used;
  logic        wptr_q, rptr_q, infl_q, oor_q;
  prio_e       prio_q, prio_d;
  logic        wr_gnt, rd_gnt, rd_elig, push, pop, wr_in_rng, rd_in_rng;
  logic        bank_cen, bank_wen;
  logic [ADDR-1:0] bank_a;
  logic [BW-1:0]   bank_d [BANKS];
  logic [BW-1:0]   bank_q [BANKS];
  logic [WW-1:0]   rd_word;
  logic [WW-1:0]   fdata_q [NB_FIFO_DEPTH];

  assign wr_in_rng = 32'(i_wr_addr) < DEPTH_U;
  assign rd_in_rng = 32'(i_rd_addr) < DEPTH_U;
  assign push      = infl_q;
  assign pop       = o_rd_valid && i_rd_ready;

  // Reads reserve a FIFO slot at grant time so a returning word always has room.
  always_comb begin
    used    = cnt_q + {1'b0, infl_q};
    rd_elig = i_rd_valid && (used < 2'(NB_FIFO_DEPTH));
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    prio_d  = prio_q;
    if (i_wr_valid && rd_elig) begin
      if (prio_q == PRIO_RD) rd_gnt = 1'b1;
      else                   wr_gnt = 1'b1;
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end else begin
      wr_gnt = i_wr_valid;
      rd_gnt = rd_elig;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  assign o_wr_ready = wr_gnt;
  assign o_rd_ready = rd_gnt;
  assign bank_cen   = !((wr_gnt && wr_in_rng) || (rd_gnt && rd_in_rng));
  assign bank_wen   = !wr_gnt;
  assign bank_a     = wr_gnt ? i_wr_addr : i_rd_addr;

  always_comb begin
    for (int k = 0; k < BANKS; k++) begin
`ifdef NB_PARITY_EN
      bank_d[k] = {^i_wr_data[k*SW +: SW], i_wr_data[k*SW +: SW]};
`else
      bank_d[k] = i_wr_data[k*SW +: SW];
`endif
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    nb_bank #(.W(BW), .DEPTH(DEPTH), .AW(ADDR)) u_bank (
      .clk_i (clk),
      .cen_i (bank_cen),
      .wen_i (bank_wen),
      .a_i   (bank_a),
      .d_i   (bank_d[g]),
      .q_o   (bank_q[g])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BANKS; k++) rd_word[k*SW +: SW] = bank_q[k][SW-1:0];
    if (oor_q) rd_word = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      infl_q <= 1'b0;
      oor_q  <= 1'b0;
      prio_q <= PRIO_WR;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_q ^ push;
      rptr_q <= rptr_q ^ pop;
      infl_q <= rd_gnt;
      oor_q  <= rd_gnt && !rd_in_rng;
      prio_q <= prio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fdata_q[wptr_q] <= rd_word;
  end

  assign o_rd_valid = cnt_q != 2'd0;
  assign o_rd_data  = fdata_q[rptr_q];

`ifdef NB_PARITY_EN
  logic rd_perr;
  logic fpar_q [NB_FIFO_DEPTH];

  // Even parity: slice plus stored bit must XOR to zero in every bank.
  always_comb begin
    rd_perr = 1'b0;
    for (int k = 0; k < BANKS; k++) rd_perr = rd_perr | (^bank_q[k]);
    if (oor_q) rd_perr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) fpar_q[wptr_q] <= rd_perr;
  end

  assign o_par_err = o_rd_valid && fpar_q[rptr_q];
`else
  assign o_par_err = 1'b0;
`endif
endmodule
